falling_letters: RTL and testbench
==================================

FALLING_LETTERS -- requirements
Module: falling_letters

Interface
REQ-001 SHALL have parameter SLOTS, default 4, the number of concurrent letter slots (1..8).
REQ-002 SHALL have parameter BOTTOM, default 9'd440, the x position at or beyond which a letter counts as missed.
REQ-003 SHALL have parameter SPAWN_FRAMES, default 8'd30, the number of frame ticks between spawn attempts.
REQ-004 SHALL have parameter MISS_LIMIT, default 8'd10, the miss count that ends the game when GAME_OVER_EN is defined.
REQ-005 SHALL have port clk, input, 1 bit: system clock; all state SHALL change on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port frame_tick, input, 1 bit: one-cycle pulse per display frame.
REQ-008 SHALL have port gen_ch, input, 8 bits: ASCII code of the candidate letter from the generator.
REQ-009 SHALL have port gen_speed, input, 3 bits: fall speed in pixels per frame, 1..7.
REQ-010 SHALL have port gen_x, input, 9 bits: start row.
REQ-011 SHALL have port gen_y, input, 10 bits: start column.
REQ-012 SHALL have port key_valid, input, 1 bit: one-cycle strobe marking a keypress.
REQ-013 SHALL have port key_code, input, 8 bits: ASCII code of the keypress.
REQ-014 SHALL have port slot_valid, output, SLOTS bits: bit i high means slot i is occupied.
REQ-015 SHALL have port slot_ch, output, 8*SLOTS bits: slot i letter at [8i+7:8i].
REQ-016 SHALL have port slot_x, output, 9*SLOTS bits: slot i row.
REQ-017 SHALL have port slot_y, output, 10*SLOTS bits: slot i column.
REQ-018 SHALL have port hit, output, 1 bit: one-cycle pulse when a keypress clears a slot.
REQ-019 SHALL have port miss, output, 1 bit: one-cycle pulse when one or more letters reach BOTTOM.
REQ-020 SHALL have port score, output, 14 bits: hit count.
REQ-021 SHALL have port miss_count, output, 8 bits: missed-letter count.
REQ-022 SHALL have port game_over, output, 1 bit: high when the game is frozen.

Function
REQ-023 SHALL keep an internal frame counter; on every frame_tick the counter SHALL increment, and when it reaches SPAWN_FRAMES-1 it SHALL wrap to 0 and raise a spawn attempt in that same cycle.
REQ-024 On a spawn attempt, gen_ch, gen_speed, gen_x and gen_y SHALL be latched into the lowest-index slot that was free at the start of the cycle; if no slot is free, the spawn SHALL be dropped silently.
REQ-025 A slot freed in the same cycle as a spawn attempt SHALL NOT be reused in that cycle.
REQ-026 On frame_tick, each occupied slot not spawned in that cycle SHALL advance x by x+speed, computed 10 bits wide.
REQ-027 If the advanced x is at or above BOTTOM, the slot SHALL be cleared instead of advanced, miss SHALL pulse once, and miss_count SHALL increase by the number of slots cleared this way, saturating at 255.
REQ-028 On key_valid, the occupied slot whose ch equals key_code and whose x is largest SHALL be cleared; on equal x, the lowest index wins.
REQ-029 A hit SHALL pulse hit and increment score, saturating at 16383; a keypress with no matching slot SHALL have no effect.
REQ-030 Keypress matching SHALL use pre-tick slot state; if key_valid and frame_tick coincide and the matched slot would also miss, the hit SHALL take precedence and no miss is counted for that slot.
REQ-031 All outputs SHALL be registered; slot state, hit, miss and the counters SHALL reflect an event exactly one clock after it.
REQ-032 A gen_speed of 0 SHALL be stored as 1.

Reset
REQ-033 While rst_n is low, independent of clk, every slot_valid bit, every slot_ch/slot_x/slot_y field, hit, miss, score, miss_count, game_over and the frame counter SHALL be 0.
REQ-034 Reset asserted mid-frame or mid-keypress SHALL discard all in-flight events; the first spawn after release SHALL occur on the SPAWN_FRAMES-th frame_tick.

Configuration
REQ-035 With macro GAME_OVER_EN defined, the block SHALL have two states, RUN and OVER.
REQ-036 With GAME_OVER_EN defined, the block SHALL move from RUN to OVER in the cycle miss_count becomes at least MISS_LIMIT.
REQ-037 With GAME_OVER_EN defined, while in OVER game_over SHALL be 1 and spawns, movement, hits and counter updates SHALL be frozen; only reset SHALL leave OVER.
REQ-038 Without GAME_OVER_EN, game_over SHALL be constant 0 and the block SHALL run indefinitely.

Verification
REQ-039 Bench: reset, SPAWN_FRAMES=3, apply 3 frame_ticks with gen_ch=8'h41, gen_speed=2, gen_x=0 -> one cycle later slot_valid=4'b0001, slot 0 ch=8'h41, x=0.
REQ-040 Bench: slot 0 at x=438, speed 2, BOTTOM=440, apply frame_tick -> slot_valid[0]=0, miss pulses for one cycle, miss_count=1.
REQ-041 Bench: slots 0 and 2 both hold 8'h43 at x=100 and x=200, apply key_valid with key_code=8'h43 -> slot 2 is cleared, hit pulses, score=1; key_code=8'h5A then has no effect.
REQ-042 Bench: all 4 slots full, reach a spawn attempt -> slot contents unchanged; clear a slot by hit in the same cycle -> no spawn into it that cycle.
REQ-043 Bench: slot at x=439 with a matching key_valid coinciding with frame_tick -> hit=1, miss=0, score increments.
REQ-044 Bench: with GAME_OVER_EN and MISS_LIMIT=2, produce two misses -> game_over=1 and slots freeze under further ticks and keys; assert rst_n low -> all outputs 0.

Source files
------------

// File: rtl/falling_letters.sv
// Falling-letters typing game core: slot table, periodic spawner, fall/miss handling and key matching.
// Optional macro GAME_OVER_EN adds a RUN/OVER state that freezes play once MISS_LIMIT misses are reached.
module falling_letters #(
    parameter int unsigned SLOTS        = 4,
    parameter logic [8:0]  BOTTOM       = 9'd440,
    parameter logic [7:0]  SPAWN_FRAMES = 8'd30,
    parameter logic [7:0]  MISS_LIMIT   = 8'd10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_tick,
    input  logic [7:0]          gen_ch,
    input  logic [2:0]          gen_speed,
    input  logic [8:0]          gen_x,
    input  logic [9:0]          gen_y,
    input  logic                key_valid,
    input  logic [7:0]          key_code,
    output logic [SLOTS-1:0]    slot_valid,
    output logic [8*SLOTS-1:0]  slot_ch,
    output logic [9*SLOTS-1:0]  slot_x,
    output logic [10*SLOTS-1:0] slot_y,
    output logic                hit,
    output logic                miss,
    output logic [13:0]         score,
    output logic [7:0]          miss_count,
    output logic                game_over
);

    logic [SLOTS-1:0]        valid_r, valid_n;
    logic [SLOTS-1:0][7:0]   ch_r, ch_n;
    logic [SLOTS-1:0][8:0]   x_r, x_n;
    logic [SLOTS-1:0][9:0]   y_r, y_n;
    logic [SLOTS-1:0][2:0]   sp_r, sp_n;
    logic [SLOTS-1:0][9:0]   adv_x_s;
    logic [7:0]              frame_cnt_r, frame_cnt_n;
    logic [13:0]             score_r, score_n;
    logic [7:0]              miss_count_r, mc_n;
    logic [8:0]              mc_sum_s;
    logic                    hit_r, miss_r;
    logic                    active_s, tick_s, spawn_s, hit_s;
    logic                    hit_found_s, free_found_s;
    logic [3:0]              hit_idx_s, free_idx_s, miss_num_s;
    logic [8:0]              best_x_s;
    logic [2:0]              spawn_sp_s;

    assign tick_s     = frame_tick & active_s;
    assign spawn_s    = tick_s && (frame_cnt_r == (SPAWN_FRAMES - 8'd1));
    assign hit_s      = hit_found_s & active_s;
    assign spawn_sp_s = (gen_speed == 3'd0) ? 3'd1 : gen_speed;

    // Key match and free-slot search, both on the state held at the start of the cycle
    always_comb begin
        hit_found_s  = 1'b0;
        hit_idx_s    = 4'd0;
        best_x_s     = 9'd0;
        free_found_s = 1'b0;
        free_idx_s   = 4'd0;
        for (int i = 0; i < SLOTS; i++) begin
            // strict '>' keeps the lowest index on equal x
            if (key_valid && valid_r[i] && (ch_r[i] == key_code) &&
                (!hit_found_s || (x_r[i] > best_x_s))) begin
                hit_found_s = 1'b1;
                hit_idx_s   = i[3:0];
                best_x_s    = x_r[i];
            end else begin
                hit_found_s = hit_found_s;
            end
            if (!free_found_s && !valid_r[i]) begin
                free_found_s = 1'b1;
                free_idx_s   = i[3:0];
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    // Per-slot next state: a hit beats a miss, and a spawned slot is not advanced this cycle
    always_comb begin
        valid_n    = valid_r;
        ch_n       = ch_r;
        x_n        = x_r;
        y_n        = y_r;
        sp_n       = sp_r;
        adv_x_s    = '0;
        miss_num_s = 4'd0;
        for (int i = 0; i < SLOTS; i++) begin
            adv_x_s[i] = {1'b0, x_r[i]} + {7'd0, sp_r[i]};
            if (hit_s && (hit_idx_s == i[3:0])) begin
                valid_n[i] = 1'b0;
            end else if (tick_s && valid_r[i]) begin
                if (adv_x_s[i] >= {1'b0, BOTTOM}) begin
                    valid_n[i] = 1'b0;
                    miss_num_s = miss_num_s + 4'd1;
                end else begin
                    x_n[i] = adv_x_s[i][8:0];
                end
            end else if (spawn_s && free_found_s && (free_idx_s == i[3:0])) begin
                valid_n[i] = 1'b1;
                ch_n[i]    = gen_ch;
                x_n[i]     = gen_x;
                y_n[i]     = gen_y;
                sp_n[i]    = spawn_sp_s;
            end else begin
                valid_n[i] = valid_r[i];
            end
        end
    end

    // Frame counter and saturating score/miss counters
    always_comb begin
        if (tick_s) begin
            frame_cnt_n = spawn_s ? 8'd0 : (frame_cnt_r + 8'd1);
        end else begin
            frame_cnt_n = frame_cnt_r;
        end
        if (hit_s && (score_r != 14'h3FFF)) begin
            score_n = score_r + 14'd1;
        end else begin
            score_n = score_r;
        end
        mc_sum_s = {1'b0, miss_count_r} + {5'd0, miss_num_s};
        if (mc_sum_s > 9'd255) begin
            mc_n = 8'd255;
        end else begin
            mc_n = mc_sum_s[7:0];
        end
    end

    // Slot table, event pulses and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r      <= '0;
            ch_r         <= '0;
            x_r          <= '0;
            y_r          <= '0;
            sp_r         <= '0;
            frame_cnt_r  <= 8'd0;
            score_r      <= 14'd0;
            miss_count_r <= 8'd0;
            hit_r        <= 1'b0;
            miss_r       <= 1'b0;
        end else begin
            valid_r      <= valid_n;
            ch_r         <= ch_n;
            x_r          <= x_n;
            y_r          <= y_n;
            sp_r         <= sp_n;
            frame_cnt_r  <= frame_cnt_n;
            score_r      <= score_n;
            miss_count_r <= mc_n;
            hit_r        <= hit_s;
            miss_r       <= (miss_num_s != 4'd0);
        end
    end

`ifdef GAME_OVER_EN
    typedef enum logic {RUN = 1'b0, OVER = 1'b1} state_t;
    state_t state_r, state_n;

    // OVER is entered on the same edge that lifts miss_count to the limit
    always_comb begin
        state_n = state_r;
        case (state_r)
            RUN: begin
                if (mc_n >= MISS_LIMIT) begin
                    state_n = OVER;
                end else begin
                    state_n = RUN;
                end
            end
            OVER:    state_n = OVER;
            default: state_n = RUN;
        endcase
    end

    // Game state register; only reset leaves OVER
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
        end else begin
            state_r <= state_n;
        end
    end

    assign active_s  = (state_r == RUN);
    assign game_over = (state_r == OVER);
`else
    logic unused_limit_s;
    assign unused_limit_s = ^MISS_LIMIT;
    assign active_s       = 1'b1;
    assign game_over      = 1'b0;
`endif

    assign slot_valid = valid_r;
    assign slot_ch    = ch_r;
    assign slot_x     = x_r;
    assign slot_y     = y_r;
    assign hit        = hit_r;
    assign miss       = miss_r;
    assign score      = score_r;
    assign miss_count = miss_count_r;

endmodule

// File: tb/tb_falling_letters.sv
// Self-checking bench for falling_letters: directed scenarios plus random play against a slot-list model.
module tb_falling_letters;

    localparam int SL  = 4;
    localparam int BOT = 440;
    localparam int SF  = 3;
    localparam int ML  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic [7:0]  gen_ch = 8'h00;
    logic [2:0]  gen_speed = 3'd0;
    logic [8:0]  gen_x = 9'd0;
    logic [9:0]  gen_y = 10'd0;
    logic        key_valid = 1'b0;
    logic [7:0]  key_code = 8'h00;
    logic [SL-1:0]    slot_valid;
    logic [8*SL-1:0]  slot_ch;
    logic [9*SL-1:0]  slot_x;
    logic [10*SL-1:0] slot_y;
    logic        hit, miss, game_over;
    logic [13:0] score;
    logic [7:0]  miss_count;

    int checks = 0;
    int errors = 0;
    bit go_exp;

    // reference model state
    bit         m_v[SL];
    logic [7:0] m_ch[SL];
    int         m_x[SL], m_y[SL], m_sp[SL];
    int         m_cnt, m_score, m_mc;
    bit         m_hit, m_miss, m_over;

    falling_letters #(
        .SLOTS(SL), .BOTTOM(9'd440), .SPAWN_FRAMES(8'd3), .MISS_LIMIT(8'd2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .gen_ch(gen_ch), .gen_speed(gen_speed), .gen_x(gen_x), .gen_y(gen_y),
        .key_valid(key_valid), .key_code(key_code),
        .slot_valid(slot_valid), .slot_ch(slot_ch), .slot_x(slot_x), .slot_y(slot_y),
        .hit(hit), .miss(miss), .score(score), .miss_count(miss_count), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SL; i++) begin
            m_v[i] = 1'b0; m_ch[i] = 8'h00; m_x[i] = 0; m_y[i] = 0; m_sp[i] = 0;
        end
        m_cnt = 0; m_score = 0; m_mc = 0; m_hit = 0; m_miss = 0; m_over = 0;
    endtask

    // one clock of game rules applied to the list of slots
    task automatic model_step(input bit ft, input bit kv, input logic [7:0] kc);
        int hidx, fidx, nm;
        bit spawn;
        m_hit = 0; m_miss = 0;
        if (m_over) return;
        spawn = ft && (m_cnt == SF - 1);
        if (ft) m_cnt = spawn ? 0 : m_cnt + 1;
        hidx = -1;
        if (kv)
            for (int i = 0; i < SL; i++)
                if (m_v[i] && m_ch[i] == kc && (hidx < 0 || m_x[i] > m_x[hidx])) hidx = i;
        fidx = -1;
        for (int i = 0; i < SL; i++)
            if (!m_v[i] && fidx < 0) fidx = i;
        nm = 0;
        for (int i = 0; i < SL; i++) begin
            if (i == hidx) m_v[i] = 0;
            else if (m_v[i] && ft) begin
                if (m_x[i] + m_sp[i] >= BOT) begin m_v[i] = 0; nm++; end
                else m_x[i] = m_x[i] + m_sp[i];
            end
        end
        if (spawn && fidx >= 0) begin
            m_v[fidx] = 1; m_ch[fidx] = gen_ch; m_x[fidx] = gen_x; m_y[fidx] = gen_y;
            m_sp[fidx] = (gen_speed == 0) ? 1 : gen_speed;
        end
        m_hit = (hidx >= 0);
        if (m_hit && m_score < 16383) m_score++;
        m_miss = (nm > 0);
        m_mc = (m_mc + nm > 255) ? 255 : m_mc + nm;
`ifdef GAME_OVER_EN
        if (m_mc >= ML) m_over = 1;
`endif
    endtask

    task automatic check_all(input string tag);
        logic [SL-1:0] ev;
        logic [8*SL-1:0] ech, och;
        logic [9*SL-1:0] ex, ox;
        logic [10*SL-1:0] ey, oy;
        ev = '0; ech = '0; och = '0; ex = '0; ox = '0; ey = '0; oy = '0;
        for (int i = 0; i < SL; i++) begin
            ev[i] = m_v[i];
            if (m_v[i]) begin
                ech[8*i +: 8] = m_ch[i]; ex[9*i +: 9] = m_x[i][8:0]; ey[10*i +: 10] = m_y[i][9:0];
            end
            if (slot_valid[i] === 1'b1) begin
                och[8*i +: 8] = slot_ch[8*i +: 8]; ox[9*i +: 9] = slot_x[9*i +: 9];
                oy[10*i +: 10] = slot_y[10*i +: 10];
            end
        end
        chk({tag, ".valid"}, slot_valid, ev);
        chk({tag, ".ch"}, och, ech);
        chk({tag, ".x"}, ox, ex);
        chk({tag, ".y"}, oy, ey);
        chk({tag, ".hit"}, hit, m_hit);
        chk({tag, ".miss"}, miss, m_miss);
        chk({tag, ".score"}, score, m_score);
        chk({tag, ".miss_count"}, miss_count, m_mc);
        chk({tag, ".game_over"}, game_over, m_over);
    endtask

    task automatic cycle(input bit ft, input bit kv, input logic [7:0] kc, input string tag);
        frame_tick = ft; key_valid = kv; key_code = kc;
        @(posedge clk);
        model_step(ft, kv, kc);
        #1;
        check_all(tag);
        frame_tick = 1'b0; key_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.valid", slot_valid, 0);
        chk("rst.ch", slot_ch, 0);
        chk("rst.x", slot_x, 0);
        chk("rst.y", slot_y, 0);
        chk("rst.pulses", {hit, miss, game_over}, 0);
        chk("rst.counters", {score, miss_count}, 0);
        frame_tick = 1'b0; key_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic spawn_letter(input logic [7:0] ch, input logic [2:0] sp,
                                input logic [8:0] x, input logic [9:0] y);
        gen_ch = ch; gen_speed = sp; gen_x = x; gen_y = y;
        for (int n = 0; n < SF; n++) begin
            if (m_cnt == SF - 1) begin
                cycle(1'b1, 1'b0, 8'h00, "spawn");
                break;
            end
            cycle(1'b1, 1'b0, 8'h00, "pre_spawn");
        end
    endtask

    initial begin
`ifdef GAME_OVER_EN
        go_exp = 1'b1;
`else
        go_exp = 1'b0;
`endif
        model_reset();

        // first spawn lands on the third tick
        do_reset();
        gen_ch = 8'h41; gen_speed = 3'd2; gen_x = 9'd0; gen_y = 10'd7;
        cycle(1'b1, 1'b0, 8'h00, "spawn_t1");
        cycle(1'b1, 1'b0, 8'h00, "spawn_t2");
        cycle(1'b1, 1'b0, 8'h00, "spawn_t3");
        chk("spawn.valid", slot_valid, 4'b0001);
        chk("spawn.ch", slot_ch[7:0], 8'h41);
        chk("spawn.x", slot_x[8:0], 9'd0);

        // letter reaching BOTTOM
        do_reset();
        spawn_letter(8'h42, 3'd2, 9'd438, 10'd0);
        chk("miss.start_x", slot_x[8:0], 9'd438);
        cycle(1'b1, 1'b0, 8'h00, "miss_tick");
        chk("miss.valid0", slot_valid[0], 1'b0);
        chk("miss.pulse", miss, 1'b1);
        chk("miss.count", miss_count, 8'd1);
        cycle(1'b0, 1'b0, 8'h00, "miss_after");
        chk("miss.pulse_end", miss, 1'b0);

        // key picks the lowest letter among duplicates
        do_reset();
        spawn_letter(8'h43, 3'd1, 9'd94, 10'd1);
        spawn_letter(8'h51, 3'd1, 9'd0, 10'd2);
        spawn_letter(8'h43, 3'd1, 9'd200, 10'd3);
        chk("key.x0", slot_x[8:0], 9'd100);
        chk("key.x2", slot_x[26:18], 9'd200);
        cycle(1'b0, 1'b1, 8'h43, "key_hit");
        chk("key.valid", slot_valid, 4'b0011);
        chk("key.hit", hit, 1'b1);
        chk("key.score", score, 14'd1);
        cycle(1'b0, 1'b1, 8'h5A, "key_nomatch");
        chk("nokey.valid", slot_valid, 4'b0011);
        chk("nokey.hit", hit, 1'b0);
        chk("nokey.score", score, 14'd1);

        // full table drops spawns; slot freed by a hit is not reused that cycle
        do_reset();
        spawn_letter(8'h41, 3'd1, 9'd0, 10'd10);
        spawn_letter(8'h42, 3'd1, 9'd0, 10'd11);
        spawn_letter(8'h43, 3'd1, 9'd0, 10'd12);
        spawn_letter(8'h44, 3'd1, 9'd0, 10'd13);
        gen_ch = 8'h45; gen_x = 9'd5;
        for (int n = 0; n < SF; n++) cycle(1'b1, 1'b0, 8'h00, "full");
        chk("full.valid", slot_valid, 4'b1111);
        chk("full.ch", slot_ch, 32'h44434241);
        for (int n = 0; n < SF - 1; n++) cycle(1'b1, 1'b0, 8'h00, "full_pre");
        cycle(1'b1, 1'b1, 8'h42, "full_hit_spawn");
        chk("reuse.valid", slot_valid, 4'b1101);
        chk("reuse.hit", hit, 1'b1);

        // hit beats miss on the same tick
        do_reset();
        spawn_letter(8'h45, 3'd1, 9'd439, 10'd0);
        cycle(1'b1, 1'b1, 8'h45, "hit_vs_miss");
        chk("hvm.hit", hit, 1'b1);
        chk("hvm.miss", miss, 1'b0);
        chk("hvm.score", score, 14'd1);
        chk("hvm.miss_count", miss_count, 8'd0);

        // two misses: game over (when enabled) freezes the table
        do_reset();
        spawn_letter(8'h41, 3'd1, 9'd10, 10'd0);
        spawn_letter(8'h42, 3'd2, 9'd438, 10'd0);
        cycle(1'b1, 1'b0, 8'h00, "go_miss1");
        spawn_letter(8'h42, 3'd2, 9'd438, 10'd0);
        cycle(1'b1, 1'b0, 8'h00, "go_miss2");
        chk("go.miss_count", miss_count, 8'd2);
        chk("go.flag", game_over, go_exp);
        chk("go.valid", slot_valid, 4'b0001);
        cycle(1'b1, 1'b1, 8'h41, "go_key");
        chk("go.frozen_valid", slot_valid, go_exp ? 4'b0001 : 4'b0000);
        chk("go.frozen_hit", hit, !go_exp);
        for (int n = 0; n < 5; n++) cycle(1'b1, 1'b0, 8'h00, "go_ticks");
        do_reset();

        // random play with a reset dropped in mid-event
        for (int n = 0; n < 800; n++) begin
            bit ft, kv;
            logic [7:0] kc;
            int pick;
            gen_ch = 8'h41 + 8'($urandom_range(0, 3));
            gen_speed = 3'($urandom_range(0, 7));
            gen_x = 9'($urandom_range(0, 511));
            gen_y = 10'($urandom_range(0, 1023));
            ft = ($urandom_range(0, 1) == 1);
            kv = ($urandom_range(0, 2) == 0);
            pick = $urandom_range(0, SL - 1);
            kc = (m_v[pick] && $urandom_range(0, 1) == 1) ? m_ch[pick] : (8'h41 + 8'($urandom_range(0, 4)));
            if (n == 400) begin
                frame_tick = 1'b1; key_valid = 1'b1; key_code = kc;
                do_reset();
            end
            cycle(ft, kv, kc, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
